// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one unified instruction/data memory between two requesters.
//   Port 0 is the CPU. Port 1 is the loader/debug master.
//   Accesses are serialised through IDLE -> ACC -> RESP using a req/ack
//   handshake, and arbitration is either round-robin or fixed CPU priority.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   mN_req/we/addr/wdata
//                     requester N; all four are held stable until mN_ack
//   mN_ack            one-cycle completion pulse, issued in RESP
//   mN_rdata          read data register, loaded at the end of ACC
//   mem_addr/wdata/read/write
//                     memory side; all zero outside ACC
//   mem_rdata         combinational read data from the memory
//   busy              high whenever the FSM is not IDLE
//   grant_id          port that owns the current (or last) transaction
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_id
);

    typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

    state_t state, state_nxt;
    logic   gnt_q, gnt_nxt, grant_fire;
    logic   last_q;   // last-granted port; starts at 1 so port 0 wins the first tie
    logic   acc_we;

    assign acc_we   = gnt_q ? m1_we : m0_we;
    assign grant_id = gnt_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (grant_fire) begin
                gnt_q  <= gnt_nxt;
                last_q <= gnt_nxt;
            end
            // Read data is captured only on reads; on a write it keeps its old value.
            if (state == ACC && !acc_we) begin
                if (gnt_q) m1_rdata <= mem_rdata;
                else       m0_rdata <= mem_rdata;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt_q;
        grant_fire = 1'b0;
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_nxt  = ACC;
                    grant_fire = 1'b1;
                    if (m0_req && m1_req) gnt_nxt = FIXED_PRI ? 1'b0 : ~last_q;
                    else                  gnt_nxt = m1_req;
                end
            end
            ACC: state_nxt = RESP;
            RESP: begin
                // Only the other port can be granted here. That alternates the
                // ports under contention and keeps port 1 alive under FIXED_PRI.
                if (gnt_q ? m0_req : m1_req) begin
                    state_nxt  = ACC;
                    grant_fire = 1'b1;
                    gnt_nxt    = ~gnt_q;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (state == ACC) begin
            mem_addr  = gnt_q ? m1_addr  : m0_addr;
            mem_wdata = gnt_q ? m1_wdata : m0_wdata;
            // Gating with rst keeps a reset that lands in ACC from committing a write.
            mem_write = acc_we  & ~rst;
            mem_read  = ~acc_we & ~rst;
        end
        m0_ack = (state == RESP) && !gnt_q;
        m1_ack = (state == RESP) &&  gnt_q;
        busy   = (state != IDLE);
    end

endmodule
